// File: rtl/cmd_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : cmd_packetizer
// Purpose  : Buffers ALU command requests in an in-order FIFO, drops cmd=0
//            requests, and issues each buffered request as a tagged 70-bit
//            packet using round-robin tags. A tag stays busy until the
//            downstream stage reports its completion.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_packetizer #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [3:0]             req_cmd,
  input  logic [31:0]            req_data1,
  input  logic [31:0]            req_data2,
  input  logic                   out_ready,
  output logic [69:0]            paket_out,
  output logic                   paket_valid,
  input  logic                   cpl_valid,
  input  logic [1:0]             cpl_tag,
  output logic [3:0]             busy_tags,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]             drop_cnt
);

  localparam int              c_AW       = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_CNT_FULL = (c_AW + 1)'(DEPTH);
  localparam logic [c_AW:0]   c_CNT_ONE  = (c_AW + 1)'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
  localparam logic [7:0]      c_DROP_MAX = 8'hFF;

  // FIFO storage: {cmd, data1, data2}; the tag is attached only at issue
  logic [67:0]     mem_q [DEPTH];

  logic [c_AW:0]   count_q,    count_d;
  logic [c_AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [c_AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [1:0]      next_tag_q, next_tag_d;
  logic [3:0]      busy_q,     busy_d;
  logic [7:0]      drop_q,     drop_d;
  logic            pvalid_q,   pvalid_d;
  logic [69:0]     pkt_q,      pkt_d;

  logic            w_accept;
  logic            w_push;
  logic            w_drop;
  logic            w_pop;

  // Ready depends only on the registered occupancy, so a same-cycle pop never raises it
  assign req_ready = reset && (count_q < c_CNT_FULL);

  // Next-state computation: accept/drop, issue decision, tag bookkeeping
  always_comb begin
    w_accept = req_valid && req_ready;
    w_drop   = w_accept && (req_cmd == 4'd0);
    w_push   = w_accept && (req_cmd != 4'd0);
    // Issue strictly uses the next tag in sequence; a busy tag stalls the whole queue
    w_pop    = (count_q != '0) && out_ready && !busy_q[next_tag_q];

    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + c_CNT_ONE;
    end else if (!w_push && w_pop) begin
      count_d = count_q - c_CNT_ONE;
    end

    wr_ptr_d   = w_push ? (wr_ptr_q + c_PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = w_pop  ? (rd_ptr_q + c_PTR_ONE) : rd_ptr_q;
    next_tag_d = w_pop  ? (next_tag_q + 2'd1)    : next_tag_q;

    // Clearing a non-busy tag is a no-op; the issue set is applied last so it wins
    busy_d = busy_q;
    if (cpl_valid) begin
      busy_d[cpl_tag] = 1'b0;
    end
    if (w_pop) begin
      busy_d[next_tag_q] = 1'b1;
    end

    drop_d = (w_drop && (drop_q != c_DROP_MAX)) ? (drop_q + 8'd1) : drop_q;

    pvalid_d = w_pop;
    pkt_d    = w_pop ? {next_tag_q, mem_q[rd_ptr_q]} : '0;
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      next_tag_q <= 2'd0;
      busy_q     <= 4'd0;
      drop_q     <= 8'd0;
      pvalid_q   <= 1'b0;
      pkt_q      <= '0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      next_tag_q <= next_tag_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      pvalid_q   <= pvalid_d;
      pkt_q      <= pkt_d;
    end
  end

  // FIFO payload write; contents are don't-care until the pointers reference them
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      mem_q[wr_ptr_q] <= {req_cmd, req_data1, req_data2};
    end
  end

  assign paket_out   = pkt_q;
  assign paket_valid = pvalid_q;
  assign busy_tags   = busy_q;
  assign fifo_count  = count_q;
  assign drop_cnt    = drop_q;

endmodule
`default_nettype wire

// File: doc/cmd_packetizer.md
CMD_PACKETIZER -- requirements
Module: cmd_packetizer

Interface
REQ-001 Parameter: DEPTH, 4, request FIFO entries (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 req_valid  input  1  upstream request present.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_cmd  input  4  operation code (1 add, 2 sub, 5 shl, 6 shr; others forwarded unchanged).
REQ-007 req_data1  input  32  first operand.
REQ-008 req_data2  input  32  second operand.
REQ-009 out_ready  input  1  downstream ALU stage accepts a packet this cycle.
REQ-010 paket_out  output  70  issued packet: [69:68] tag, [67:64] cmd, [63:32] data1, [31:0] data2.
REQ-011 paket_valid  output  1  paket_out holds an issued packet this cycle.
REQ-012 cpl_valid  input  1  downstream reports completion of a tag.
REQ-013 cpl_tag  input  2  tag being completed.
REQ-014 busy_tags  output  4  bit i set = tag i outstanding.
REQ-015 fifo_count  output  $clog2(DEPTH)+1  entries currently buffered.
REQ-016 drop_cnt  output  8  saturating count of discarded cmd=0 requests.

Function
REQ-017 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-018 req_ready SHALL be 1 exactly when registered fifo_count < DEPTH; a pop in the same cycle does not raise it.
REQ-019 An accepted request with req_cmd=0 SHALL be discarded (not buffered, no tag), and drop_cnt incremented, saturating at 255.
REQ-020 Accepted requests with req_cmd!=0 SHALL be stored in order in the FIFO; push and pop in the same cycle leave fifo_count unchanged.
REQ-021 A tag counter next_tag (2 bits) SHALL allocate tags round-robin 0,1,2,3,0; it wraps 3->0.
REQ-022 Issue occurs on an edge where fifo non-empty, out_ready=1 and busy_tags[next_tag]=0; head entry popped, packet registered with tag=next_tag, busy_tags[next_tag] set, next_tag incremented.
REQ-023 If busy_tags[next_tag]=1, issue SHALL stall (no skip to a free tag); order of issue equals order of acceptance.
REQ-024 paket_valid SHALL be high for exactly one cycle per issue; paket_out SHALL be all zeros whenever paket_valid=0.
REQ-025 Latency: request accepted at edge N into an empty FIFO with a free tag and out_ready=1 SHALL be popped at edge N+1 and appear on paket_out/paket_valid after edge N+1.
REQ-026 cpl_valid=1 SHALL clear busy_tags[cpl_tag] at the next edge; completion of a non-busy tag is ignored.
REQ-027 Completion of tag T and issue stalled on T in the same cycle: issue waits one cycle (uses registered busy_tags).
REQ-028 out_ready=0 SHALL hold the FIFO and tag state unchanged; no packet is lost or duplicated.
REQ-029 Maximum outstanding tags SHALL be 4; with all busy, no issue until a completion.

Reset
REQ-030 While reset=0 at an edge: FIFO flushed, fifo_count=0, busy_tags=0, next_tag=0, drop_cnt=0, paket_valid=0, paket_out=0.
REQ-031 req_ready SHALL be 0 while reset=0 and 1 on the first cycle after reset release.
REQ-032 Reset asserted mid-operation SHALL discard buffered and in-flight requests; later completions for old tags are ignored.

Verification
REQ-033 Single op: req cmd=1, d1=5, d2=7, out_ready=1 -> one cycle later paket_out=70'h0_1_00000005_00000007 with tag 0, busy_tags=4'b0001.
REQ-034 Fill: 5 back-to-back reqs, out_ready=0 -> 4 accepted, req_ready=0 on 5th, fifo_count=4; raise out_ready -> packets tags 0..3 in order, 5th request then accepted.
REQ-035 Tag exhaustion: issue 4 packets, no completions, 5th queued -> no issue; cpl_valid with cpl_tag=0 -> 5th issues with tag 0 two cycles later.
REQ-036 Drop: req cmd=0 -> no paket_valid, drop_cnt=1; 300 such reqs -> drop_cnt=255.
REQ-037 Reset mid-run: 3 buffered, 2 busy tags, reset=0 one cycle -> all outputs zero, next issue uses tag 0.
REQ-038 Bogus completion: cpl_tag=2 while busy_tags=4'b0001 -> busy_tags unchanged.
